// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding and default widths for the two-port memory arbiter
package mem_arb_pkg;
  localparam int DEFAULT_ADDR_W = 5;
  localparam int DEFAULT_DATA_W = 8;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;
endpackage

// File: rtl/arb_req_mux.sv
// arb_req_mux: selects the granted requester's operands for the operand latch
module arb_req_mux #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              sel,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              we,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata
);
  always_comb begin
    we    = sel ? we1 : we0;
    addr  = sel ? addr1 : addr0;
    wdata = sel ? wdata1 : wdata0;
  end
endmodule

// File: rtl/mem_arbiter_2p.sv
// mem_arbiter_2p: two-port round-robin sequencer of single-byte accesses to one shared memory
module mem_arbiter_2p
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              CLK,
  input  logic              R,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic [1:0]        gnt,
  output logic [ADDR_W-1:0] mem_A,
  output logic [DATA_W-1:0] mem_D,
  output logic              mem_RE,
  output logic              mem_WE,
  input  logic [DATA_W-1:0] mem_out
);
  state_t            state, state_nx;
  logic              ptr, own, sel, start;
  logic              op_we, mx_we;
  logic [ADDR_W-1:0] op_addr, mx_addr;
  logic [DATA_W-1:0] op_wdata, mx_wdata;
  assign sel   = (req0 & req1) ? ptr : req1;
  assign start = (state == IDLE) && (req0 | req1);
  arb_req_mux #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mux (
    .sel(sel),
    .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .we(mx_we), .addr(mx_addr), .wdata(mx_wdata)
  );
  always_ff @(posedge CLK)
    state <= R ? IDLE : state_nx;
  always_comb begin
    state_nx = IDLE;
    state_nx = (state == IDLE) ? (start ? ACCESS : IDLE) : (state == ACCESS) ? RESP : IDLE;
  end
  always_comb begin
    gnt    = (state == IDLE) ? 2'b00 : {own, ~own};
    ack0   = (state == RESP) && !own;
    ack1   = (state == RESP) && own;
    mem_RE = (state == ACCESS) && !op_we;
    mem_WE = (state == ACCESS) && op_we;
    mem_A  = (state == ACCESS) ? op_addr : '0;
    mem_D  = ((state == ACCESS) && op_we) ? op_wdata : '0;
  end
  always_ff @(posedge CLK)
    if (R) begin
      ptr      <= 1'b0;
      own      <= 1'b0;
      op_we    <= 1'b0;
      op_addr  <= '0;
      op_wdata <= '0;
      rdata0   <= '0;
      rdata1   <= '0;
    end else begin
      if (start) begin
        own      <= sel;
        op_we    <= mx_we;
        op_addr  <= mx_addr;
        op_wdata <= mx_wdata;
      end
      if ((state == ACCESS) && !op_we && !own) rdata0 <= mem_out;
      if ((state == ACCESS) && !op_we && own) rdata1 <= mem_out;
      if (state == RESP) ptr <= ~own;
    end
endmodule

// File: tb/tb_mem_arbiter_2p.sv
// tb_mem_arbiter_2p: directed vector bench for the two-port memory arbiter with a behavioural 32-byte memory
module tb_mem_arbiter_2p;
  logic       CLK = 1'b0, R = 1'b1, fill = 1'b1;
  logic       req0 = 0, we0 = 0, req1 = 0, we1 = 0;
  logic [4:0] addr0 = 0, addr1 = 0;
  logic [7:0] wdata0 = 0, wdata1 = 0;
  logic       ack0, ack1, mem_RE, mem_WE;
  logic [7:0] rdata0, rdata1, mem_D, mem_out;
  logic [1:0] gnt;
  logic [4:0] mem_A;
  logic [7:0] mem [32];
  int errors = 0, checks = 0;

  always #50 CLK = ~CLK;

  always @(posedge CLK)
    if (fill) for (int k = 0; k < 32; k++) mem[k] <= 8'hA0 | 8'(k);
    else if (mem_WE) mem[mem_A] <= mem_D;

  assign mem_out = mem_RE ? mem[mem_A] : 8'h00;

  mem_arbiter_2p dut (
    .CLK(CLK), .R(R),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
    .gnt(gnt), .mem_A(mem_A), .mem_D(mem_D), .mem_RE(mem_RE), .mem_WE(mem_WE), .mem_out(mem_out)
  );

  typedef struct {
    logic r, q0, w0; logic [4:0] a0; logic [7:0] d0;
    logic q1, w1;    logic [4:0] a1; logic [7:0] d1;
  } in_t;
  typedef struct {
    logic [1:0] g; logic k0, k1; logic [7:0] rd0, rd1;
    logic re, we; logic [4:0] ma; logic [7:0] md;
  } out_t;
  typedef struct {in_t i; out_t o;} vec_t;
  vec_t tv[$];

  function automatic in_t iv(input logic r, q0, w0, input logic [4:0] a0, input logic [7:0] d0,
                             input logic q1, w1, input logic [4:0] a1, input logic [7:0] d1);
    in_t t;
    t.r = r; t.q0 = q0; t.w0 = w0; t.a0 = a0; t.d0 = d0;
    t.q1 = q1; t.w1 = w1; t.a1 = a1; t.d1 = d1;
    return t;
  endfunction

  function automatic out_t ov(input logic [1:0] g, input logic k0, k1, input logic [7:0] rd0, rd1,
                              input logic re, we, input logic [4:0] ma, input logic [7:0] md);
    out_t t;
    t.g = g; t.k0 = k0; t.k1 = k1; t.rd0 = rd0; t.rd1 = rd1;
    t.re = re; t.we = we; t.ma = ma; t.md = md;
    return t;
  endfunction

  function automatic out_t idl(input logic [7:0] rd0, rd1);
    return ov(2'b00, 0, 0, rd0, rd1, 0, 0, 5'h00, 8'h00);
  endfunction

  function automatic in_t none(input logic r);
    return iv(r, 0, 0, 5'h00, 8'h00, 0, 0, 5'h00, 8'h00);
  endfunction

  task automatic add(input in_t i, input out_t o);
    vec_t t;
    t.i = i;
    t.o = o;
    tv.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input string tag, input in_t i, input out_t o);
    R = i.r; req0 = i.q0; we0 = i.w0; addr0 = i.a0; wdata0 = i.d0;
    req1 = i.q1; we1 = i.w1; addr1 = i.a1; wdata1 = i.d1;
    @(negedge CLK);
    chk({tag, ".gnt"}, 32'(gnt), 32'(o.g));
    chk({tag, ".ack0"}, 32'(ack0), 32'(o.k0));
    chk({tag, ".ack1"}, 32'(ack1), 32'(o.k1));
    chk({tag, ".rdata0"}, 32'(rdata0), 32'(o.rd0));
    chk({tag, ".rdata1"}, 32'(rdata1), 32'(o.rd1));
    chk({tag, ".mem_RE"}, 32'(mem_RE), 32'(o.re));
    chk({tag, ".mem_WE"}, 32'(mem_WE), 32'(o.we));
    chk({tag, ".mem_A"}, 32'(mem_A), 32'(o.ma));
    chk({tag, ".mem_D"}, 32'(mem_D), 32'(o.md));
    @(posedge CLK);
    #1;
  endtask

  initial begin
    in_t both;
    both = iv(0, 1, 0, 5'h00, 8'h00, 1, 0, 5'h01, 8'h00);
    add(none(1), idl(8'h00, 8'h00));
    add(iv(0, 1, 1, 5'h1D, 8'h25, 0, 0, 5'h00, 8'h00), idl(8'h00, 8'h00));
    add(none(0), ov(2'b01, 0, 0, 8'h00, 8'h00, 0, 1, 5'h1D, 8'h25));
    add(iv(0, 1, 0, 5'h1D, 8'h00, 0, 0, 5'h00, 8'h00), ov(2'b01, 1, 0, 8'h00, 8'h00, 0, 0, 5'h00, 8'h00));
    add(iv(0, 1, 0, 5'h1D, 8'h00, 0, 0, 5'h00, 8'h00), idl(8'h00, 8'h00));
    add(none(0), ov(2'b01, 0, 0, 8'h00, 8'h00, 1, 0, 5'h1D, 8'h00));
    add(none(0), ov(2'b01, 1, 0, 8'h25, 8'h00, 0, 0, 5'h00, 8'h00));
    add(none(1), idl(8'h25, 8'h00));
    add(iv(0, 1, 1, 5'h13, 8'h15, 1, 0, 5'h0B, 8'h00), idl(8'h00, 8'h00));
    add(iv(0, 0, 0, 5'h00, 8'h00, 1, 0, 5'h0B, 8'h00), ov(2'b01, 0, 0, 8'h00, 8'h00, 0, 1, 5'h13, 8'h15));
    add(iv(0, 0, 0, 5'h00, 8'h00, 1, 0, 5'h0B, 8'h00), ov(2'b01, 1, 0, 8'h00, 8'h00, 0, 0, 5'h00, 8'h00));
    add(iv(0, 0, 0, 5'h00, 8'h00, 1, 0, 5'h0B, 8'h00), idl(8'h00, 8'h00));
    add(none(0), ov(2'b10, 0, 0, 8'h00, 8'h00, 1, 0, 5'h0B, 8'h00));
    add(none(0), ov(2'b10, 0, 1, 8'h00, 8'hAB, 0, 0, 5'h00, 8'h00));
    add(both, idl(8'h00, 8'hAB));
    add(both, ov(2'b01, 0, 0, 8'h00, 8'hAB, 1, 0, 5'h00, 8'h00));
    add(both, ov(2'b01, 1, 0, 8'hA0, 8'hAB, 0, 0, 5'h00, 8'h00));
    add(both, idl(8'hA0, 8'hAB));
    add(both, ov(2'b10, 0, 0, 8'hA0, 8'hAB, 1, 0, 5'h01, 8'h00));
    add(both, ov(2'b10, 0, 1, 8'hA0, 8'hA1, 0, 0, 5'h00, 8'h00));
    add(both, idl(8'hA0, 8'hA1));
    add(both, ov(2'b01, 0, 0, 8'hA0, 8'hA1, 1, 0, 5'h00, 8'h00));
    add(both, ov(2'b01, 1, 0, 8'hA0, 8'hA1, 0, 0, 5'h00, 8'h00));
    add(both, idl(8'hA0, 8'hA1));
    add(both, ov(2'b10, 0, 0, 8'hA0, 8'hA1, 1, 0, 5'h01, 8'h00));
    add(none(0), ov(2'b10, 0, 1, 8'hA0, 8'hA1, 0, 0, 5'h00, 8'h00));
    @(posedge CLK);
    #1;
    fill = 1'b0;
    for (int n = 0; n < tv.size(); n++) apply($sformatf("vec%0d", n), tv[n].i, tv[n].o);
    apply("opchg0", iv(0, 0, 0, 5'h00, 8'h00, 1, 1, 5'h09, 8'h18), idl(8'hA0, 8'hA1));
    apply("opchg1", iv(0, 0, 0, 5'h00, 8'h00, 0, 1, 5'h0E, 8'hFF), ov(2'b10, 0, 0, 8'hA0, 8'hA1, 0, 1, 5'h09, 8'h18));
    apply("opchg2", iv(0, 1, 0, 5'h09, 8'h00, 0, 1, 5'h0E, 8'hFF), ov(2'b10, 0, 1, 8'hA0, 8'hA1, 0, 0, 5'h00, 8'h00));
    apply("opchg3", iv(0, 1, 0, 5'h09, 8'h00, 0, 1, 5'h0E, 8'hFF), idl(8'hA0, 8'hA1));
    apply("opchg4", none(0), ov(2'b01, 0, 0, 8'hA0, 8'hA1, 1, 0, 5'h09, 8'h00));
    apply("opchg5", none(0), ov(2'b01, 1, 0, 8'h18, 8'hA1, 0, 0, 5'h00, 8'h00));
    chk("mem09", 32'(mem[9]), 32'h18);
    chk("mem0E", 32'(mem[14]), 32'hAE);
    apply("rstacc0", iv(0, 0, 0, 5'h00, 8'h00, 1, 0, 5'h13, 8'h00), idl(8'h18, 8'hA1));
    apply("rstacc1", none(1), ov(2'b10, 0, 0, 8'h18, 8'hA1, 1, 0, 5'h13, 8'h00));
    apply("rstacc2", iv(0, 1, 0, 5'h1D, 8'h00, 1, 0, 5'h13, 8'h00), idl(8'h00, 8'h00));
    apply("rstacc3", none(0), ov(2'b01, 0, 0, 8'h00, 8'h00, 1, 0, 5'h1D, 8'h00));
    apply("rstacc4", none(0), ov(2'b01, 1, 0, 8'h25, 8'h00, 0, 0, 5'h00, 8'h00));
    for (int n = 0; n < 10; n++) apply($sformatf("quiet%0d", n), none(0), idl(8'h25, 8'h00));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
